// File: rtl/alu_hazard_ctrl.sv
// rtl/alu_hazard_ctrl.sv - operand forwarding select and load-use hazard scheduler for the ALU stage
module alu_hazard_ctrl #(
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_src1,
  input  logic [RA_W-1:0]  id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             stall,
  output logic             issue,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] dst;
    logic            wr;
    logic            ld;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_t ex_q, mem_q, wb_q;
  slot_t id_slot;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;

  function automatic logic slot_hit(input slot_t s, input logic [RA_W-1:0] src,
                                    input logic use_n);
    return s.v & s.wr & (s.dst == src) & use_n;
  endfunction

  always_comb begin
    ex_hit1  = slot_hit(ex_q,  id_src1, id_use1);
    ex_hit2  = slot_hit(ex_q,  id_src2, id_use2);
    mem_hit1 = slot_hit(mem_q, id_src1, id_use1);
    mem_hit2 = slot_hit(mem_q, id_src2, id_use2);
    wb_hit1  = slot_hit(wb_q,  id_src1, id_use1);
    wb_hit2  = slot_hit(wb_q,  id_src2, id_use2);
  end

  // Youngest producer wins when several slots hold the same destination.
  always_comb begin
    fwd_sel1 = 2'd0;
    if (ex_hit1)       fwd_sel1 = 2'd1;
    else if (mem_hit1) fwd_sel1 = 2'd2;
    else if (wb_hit1)  fwd_sel1 = 2'd3;

    fwd_sel2 = 2'd0;
    if (ex_hit2)       fwd_sel2 = 2'd1;
    else if (mem_hit2) fwd_sel2 = 2'd2;
    else if (wb_hit2)  fwd_sel2 = 2'd3;
  end

  // A load still in EX has no result yet, so its consumer must wait one cycle.
  always_comb begin
    stall = id_valid & ~flush & (ex_hit1 | ex_hit2) & ex_q.ld;
    issue = id_valid & ~flush & ~stall & ~hold;
  end

  always_comb begin
    id_slot     = '0;
    id_slot.v   = 1'b1;
    id_slot.dst = id_dst;
    id_slot.wr  = id_wr;
    id_slot.ld  = id_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        ex_q <= '0;
        if (!hold) begin
          mem_q <= ex_q;
          wb_q  <= mem_q;
        end
      end else if (!hold) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= issue ? id_slot : '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_hazard_ctrl.sv
// tb/tb_alu_hazard_ctrl.sv - randomized and directed self-checking bench for alu_hazard_ctrl
module tb_alu_hazard_ctrl;

  localparam int RA_W  = 3;
  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use1, id_use2, id_wr, id_load, flush, hold;
  logic [RA_W-1:0]  id_src1, id_src2, id_dst;
  logic [1:0]       fwd_sel1, fwd_sel2;
  logic             stall, issue;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Pipeline model: index 0 = EX, 1 = MEM, 2 = WB (youngest first).
  bit m_v[3];
  int m_dst[3];
  bit m_wr[3];
  bit m_ld[3];
  int m_cnt;

  alu_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dst(id_dst), .id_wr(id_wr),
    .id_load(id_load), .flush(flush), .hold(hold), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .stall(stall), .issue(issue), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic int exp_sel(input int src, input bit use_n);
    for (int k = 0; k < 3; k++)
      if (use_n && m_v[k] && m_wr[k] && m_dst[k] == src) return k + 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit load_in_ex = m_v[0] && m_ld[0] && m_wr[0];
    bit dep = (id_use1 && m_dst[0] == int'(id_src1)) || (id_use2 && m_dst[0] == int'(id_src2));
    return id_valid && !flush && load_in_ex && dep;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit s = exp_stall();
    chk("stall", int'(stall), int'(s));
    chk("issue", int'(issue), int'(id_valid && !flush && !s && !hold));
    chk("stall_cnt", int'(stall_cnt), m_cnt);
    if (!s) begin
      chk("fwd_sel1", int'(fwd_sel1), exp_sel(int'(id_src1), id_use1));
      chk("fwd_sel2", int'(fwd_sel2), exp_sel(int'(id_src2), id_use2));
    end
  endtask

  task automatic update_model();
    bit s = exp_stall();
    bit iss = id_valid && !flush && !s && !hold;
    if (rst) begin
      for (int k = 0; k < 3; k++) m_v[k] = 0;
      m_cnt = 0;
    end else begin
      if (s && m_cnt < CMAX) m_cnt++;
      if (!hold || flush) begin
        if (!hold) begin
          for (int k = 2; k > 0; k--) begin
            m_v[k] = m_v[k-1]; m_dst[k] = m_dst[k-1];
            m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
          end
        end
        m_v[0] = iss; m_dst[0] = int'(id_dst); m_wr[0] = id_wr; m_ld[0] = id_load;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input bit v, input int s1, input int s2, input bit u1, input bit u2,
                       input int d, input bit w, input bit ld, input bit fl, input bit hd);
    id_valid = v; id_src1 = RA_W'(s1); id_src2 = RA_W'(s2); id_use1 = u1; id_use2 = u2;
    id_dst = RA_W'(d); id_wr = w; id_load = ld; flush = fl; hold = hd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_dst[k] = 0; m_wr[k] = 0; m_ld[k] = 0; end
    m_cnt = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();

    // reset state
    settle();
    chk("rst_cnt", int'(stall_cnt), 0);
    chk("rst_sel1", int'(fwd_sel1), 0);
    chk("rst_stall", int'(stall), 0);

    // 1: independent ops
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); settle(); chk("t1_issue", int'(issue), 1); tick();
    drive(1, 4, 5, 1, 1, 6, 1, 0, 0, 0); settle(); chk("t1_sel1", int'(fwd_sel1), 0); tick();
    drive(1, 1, 2, 1, 1, 7, 1, 0, 0, 0); settle(); chk("t1_sel2", int'(fwd_sel2), 0);
    chk("t1_stall", int'(stall), 0); tick();

    // 2: ADD r1 then SUB r2,r1,r3
    do_reset();
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0, 0); settle(); tick();
    drive(1, 1, 3, 1, 1, 2, 1, 0, 0, 0); settle();
    chk("t2_sel1", int'(fwd_sel1), 1); chk("t2_sel2", int'(fwd_sel2), 0);
    chk("t2_stall", int'(stall), 0); tick();

    // 3: LD r4 then ADD r5,r4,r4
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); settle(); tick();
    drive(1, 4, 4, 1, 1, 5, 1, 0, 0, 0); settle();
    chk("t3_stall", int'(stall), 1); chk("t3_issue", int'(issue), 0); tick();
    settle();
    chk("t3_sel1", int'(fwd_sel1), 2); chk("t3_sel2", int'(fwd_sel2), 2);
    chk("t3_cnt", int'(stall_cnt), 1); chk("t3_issue2", int'(issue), 1); tick();

    // 4: writers to r2 at distance 1 and 3, then with the distance-1 one not writing
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); settle(); tick();
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); settle(); tick();
      drive(1, 0, 0, 0, 0, 2, (pass == 0), 0, 0, 0); settle(); tick();
      drive(1, 2, 2, 1, 1, 7, 1, 0, 0, 0); settle();
      chk("t4_sel1", int'(fwd_sel1), (pass == 0) ? 1 : 3);
      chk("t4_sel2", int'(fwd_sel2), (pass == 0) ? 1 : 3); tick();
    end

    // 5: hold two cycles with r6 writer in EX
    do_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); settle(); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 6, 1, 1, 1, 3, 1, 0, 0, 1); settle();
      chk("t5_hold_issue", int'(issue), 0); chk("t5_hold_sel", int'(fwd_sel1), 1); tick();
    end
    drive(1, 6, 1, 1, 1, 3, 1, 0, 0, 0); settle();
    chk("t5_rel_sel", int'(fwd_sel1), 1); chk("t5_rel_issue", int'(issue), 1); tick();

    // 6: flush against load-use, then reset while a load sits in EX
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); settle(); tick();
    drive(1, 4, 4, 1, 1, 5, 1, 0, 1, 0); settle();
    chk("t6_fl_stall", int'(stall), 0); chk("t6_fl_issue", int'(issue), 0); tick();
    drive(1, 4, 0, 1, 0, 5, 1, 0, 0, 0); settle();
    chk("t6_fl_sel", int'(fwd_sel1), 2); tick();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); settle(); tick();
    drive(1, 4, 4, 1, 1, 5, 1, 0, 0, 0); rst = 1'b1; settle();
    chk("t6_pre_stall", int'(stall), 1); tick();
    rst = 1'b0; settle();
    chk("t6_rst_sel1", int'(fwd_sel1), 0); chk("t6_rst_sel2", int'(fwd_sel2), 0);
    chk("t6_rst_stall", int'(stall), 0); chk("t6_rst_cnt", int'(stall_cnt), 0);
    chk("t6_rst_issue", int'(issue), 1); tick();

    // saturation: a held load-use stall keeps counting until the ceiling
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); settle(); tick();
    for (int i = 0; i < CMAX + 8; i++) begin
      drive(1, 4, 0, 1, 0, 5, 1, 0, 0, 1); settle(); tick();
    end
    chk("sat_cnt", int'(stall_cnt), CMAX);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 5) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
